// File: rtl/serial_pkg.sv
// Shared encodings for the bit-serial ALU blocks: function codes, FSM states
// and a helper that tells defined shift functions apart from reserved codes.
package serial_pkg;

  localparam logic [2:0] FN_SLL = 3'b000;
  localparam logic [2:0] FN_SRL = 3'b001;
  localparam logic [2:0] FN_SRA = 3'b011;
  localparam logic [2:0] FN_ROL = 3'b100;
  localparam logic [2:0] FN_ROR = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  function automatic logic fn_defined(input logic [2:0] f);
    return (f == FN_SLL) || (f == FN_SRL) || (f == FN_SRA) ||
           (f == FN_ROL) || (f == FN_ROR);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Free-running wrap-around bit counter with synchronous clear (priority) and enable.
module bit_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/serial_shifter.sv
// Bit-serial barrel shifter: loads A and shamt LSB-first over XLEN cycles,
// then streams the shifted/rotated result LSB-first over the next XLEN cycles.
module serial_shifter
  import serial_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       start,
  input  logic [2:0] func,
  input  logic       op_a,
  input  logic       op_b,
  output logic       ready,
  output logic       out_bit,
  output logic       out_valid,
  output logic       out_last
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_MAX = SHW'(XLEN - 1);

  logic [1:0]      state;
  logic [1:0]      state_nx;
  logic [SHW-1:0]  cnt;
  logic            cnt_en;
  logic            capture;
  logic            at_max;

  logic [XLEN-1:0] a_q;
  logic [SHW-1:0]  shamt;
  logic [2:0]      func_q;

  logic [SHW-1:0]  idx_l;
  logic [SHW-1:0]  idx_r;
  logic            carry_r;
  logic            in_l;
  logic            in_r;
  logic            r_bit;

  assign at_max  = (cnt == CNT_MAX);
  assign capture = ((state == ST_IDLE) && start) || (state == ST_LOAD);
  assign cnt_en  = capture || (state == ST_OUT);

  bit_counter #(.W(SHW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .en    (cnt_en),
    .count (cnt)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start)  state_nx = ST_LOAD;
      ST_LOAD: if (at_max) state_nx = ST_OUT;
      ST_OUT:  if (at_max) state_nx = ST_IDLE;
      default:             state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // cnt is 0 whenever the FSM sits in IDLE, so the start edge writes bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      shamt  <= '0;
      func_q <= FN_SLL;
    end else if (capture && !flush) begin
      if (state == ST_IDLE) func_q <= func;
      a_q[cnt] <= op_a;
      for (int i = 0; i < SHW; i++) begin
        if (cnt == i[SHW-1:0]) shamt[i] <= op_b;
      end
    end
  end

  // Source index for result bit k=cnt; wraps mod XLEN, carry flags k+s >= XLEN.
  assign idx_l            = cnt - shamt;
  assign {carry_r, idx_r} = {1'b0, cnt} + {1'b0, shamt};
  assign in_l             = (cnt >= shamt);
  assign in_r             = !carry_r;

  always_comb begin
    r_bit = 1'b0;
    if (fn_defined(func_q)) begin
      case (func_q)
        FN_SLL:  r_bit = in_l ? a_q[idx_l] : 1'b0;
        FN_SRL:  r_bit = in_r ? a_q[idx_r] : 1'b0;
        FN_SRA:  r_bit = in_r ? a_q[idx_r] : a_q[XLEN-1];
        FN_ROL:  r_bit = a_q[idx_l];
        FN_ROR:  r_bit = a_q[idx_r];
        default: r_bit = 1'b0;
      endcase
    end
  end

  assign ready     = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign out_last  = out_valid && at_max;
  assign out_bit   = out_valid && r_bit;

endmodule

// File: doc/serial_shifter.md
Name: serial_shifter

Overview:
- Parametrised bit-serial barrel shifter for the bit-serial datapath.
- Captures operand A and the shift amount from operand B LSB-first over XLEN cycles, then streams the result LSB-first over the next XLEN cycles.
- Replaces the fixed 32-bit, SRL-primitive shifter. Adds arbitrary XLEN, rotate modes, start/ready handshake, flush and an end-of-word marker.
- Technology-independent: plain flops, no vendor primitives.

Parameters:
- XLEN, 32, operand and result width; power of two, 8..64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- start  in  1  begin an operation; sampled only when ready=1.
- func  in  3  mode, latched on the start edge.
- op_a  in  1  serial operand A bit, LSB first.
- op_b  in  1  serial operand B bit, LSB first; only bits 0..SHW-1 are used.
- ready  out  1  block is idle and accepts start.
- out_bit  out  1  serial result bit, LSB first.
- out_valid  out  1  out_bit is valid this cycle.
- out_last  out  1  qualifies the final result bit (index XLEN-1).

Behaviour:
- States: IDLE, LOAD, OUT. Bit counter cnt is SHW bits wide.
- Reset: rst_n=0 asynchronously forces state=IDLE, cnt=0, operand register=0, shamt=0, func register=SLL. Outputs during reset: ready=1, out_valid=0, out_last=0, out_bit=0.
- IDLE:
  - ready=1.
  - start=1 at edge E0 captures func, op_a as a[0], and op_b as b[0] (b[0] becomes shamt[0] if SHW≥1).
  - At E0: cnt←1, state←LOAD.
- LOAD (cnt=1..XLEN-1):
  - On each edge, a[cnt]←op_a; if cnt<SHW then shamt[cnt]←op_b.
  - op_b bits at index ≥SHW are ignored.
  - At cnt=XLEN-1: state←OUT, cnt←0.
  - Operand capture therefore spans edges E0..E(XLEN-1).
- OUT (cnt=k, 0..XLEN-1):
  - out_valid=1, out_bit=r[k].
  - All three are decoded from registers only (no input-to-output path).
  - out_last=1 when k=XLEN-1; on that edge state←IDLE, cnt←0.
  - The first result bit is valid in the cycle after E(XLEN-1). A back-to-back start is accepted on the cycle after out_last.
- Result r[k], with s=shamt and idx=(k±s) mod XLEN:
  - SLL 3'b000: r[k] = k≥s ? a[k-s] : 0.
  - SRL 3'b001: r[k] = k+s<XLEN ? a[k+s] : 0.
  - SRA 3'b011: r[k] = k+s<XLEN ? a[k+s] : a[XLEN-1].
  - ROL 3'b100: r[k] = a[(k-s) mod XLEN].
  - ROR 3'b101: r[k] = a[(k+s) mod XLEN].
  - Reserved codes 010, 110, 111: r[k]=0 for all k; the timing is unchanged.
- Arithmetic: idx arithmetic is SHW bits wide and wraps naturally. The k+s<XLEN comparison uses SHW+1 bits.
- Boundaries:
  - s=0 → r=a in every mode.
  - s=XLEN-1 → SLL leaves only a[0], at r[XLEN-1]; SRL leaves only a[XLEN-1], at r[0].
- Handshake rules:
  - start while ready=0 is ignored; func/op inputs are don't-care outside IDLE-start and LOAD.
- flush:
  - flush=1 in any state → state←IDLE and cnt←0 on that edge; operand contents are don't-care.
  - flush has priority over start in the same cycle; start is not accepted.
  - out_valid is 0 from the cycle after the flush edge.
- Reset mid-operation: an asynchronous abort, same end state as a flush. No partial result is emitted afterwards.

Decomposition:
- Package serial_pkg:
  - func encodings: FN_SLL, FN_SRL, FN_SRA, FN_ROL, FN_ROR.
  - State enum: ST_IDLE, ST_LOAD, ST_OUT.
  - Shared with the other serial ALU blocks.
- Sub-module bit_counter:
  - Parametrised width, asynchronous active-low reset, synchronous clear and enable.
  - Generalises the existing counter and is reused by the other serial blocks.
- Index/mask decode stays inline in serial_shifter.

Test Plan:
- XLEN=32, SLL: a=0x0000_0001, b=31 → out stream is 0x8000_0000 with out_last on bit 31; ready rises the cycle after out_last.
- SRA: a=0x8000_0010, b=4 → 0xF800_0001. Repeat with SRL → 0x0800_0001. b=0x0000_0FE4 gives the same results (upper bits ignored).
- ROR: a=0x1234_5678, b=8 → 0x7812_3456. ROL: a=0x1234_5678, b=8 → 0x3456_7812. b=0 → 0x1234_5678 in all five modes.
- Handshake: start held high for 70 cycles → exactly two operations, back-to-back (second start accepted the cycle after the first out_last). Reserved func 3'b111 → 32 zero bits, out_last still on bit 31.
- flush at LOAD cnt=10, then reset (rst_n low for 1 ns, asynchronous) at OUT k=5 of a new operation → out_valid=0 the cycle after the flush edge and immediately when rst_n falls; ready=1; the next operation (SRL a=0xFFFF_FFFF, b=1 → 0x7FFF_FFFF) is correct.
- XLEN=8 and XLEN=64 builds: SLL a=0x81, b=1 → 0x02; SRA a=0x8000_0000_0000_0000, b=63 → 0xFFFF_FFFF_FFFF_FFFF; 8 and 64 result bits respectively.
